ssram_arb: RTL
==============

SSRAM_ARB -- requirements
Module: ssram_arb

Interface
REQ-001 RD_LAT, 2, SSRAM read latency in cycles from ADSC issue edge to valid ss_q; legal range 1..4.
REQ-002 STARVE_MAX, 8, number of consecutive port-A grants with b_req pending before port B is forced a grant; legal range 1..255.
REQ-003 sys_clk  in  1  single clock for all logic.
REQ-004 xresetl  in  1  reset, asynchronous, active-low.
REQ-005 a_req  in  1  port A (Jaguar DRAM side) request; held until a_rdy.
REQ-006 a_we  in  1  port A write (1) / read (0); stable while a_req.
REQ-007 a_addr  in  18  port A 64-bit word address.
REQ-008 a_be_n  in  8  port A byte enables, active-low; [7:4] high word, [3:0] low word.
REQ-009 a_d  in  64  port A write data.
REQ-010 a_q  out  64  port A read data; [63:32] from even SSRAM word, [31:0] from odd.
REQ-011 a_rdy  out  1  port A completion pulse.
REQ-012 b_req  in  1  port B (loader/debug) request; held until b_ack.
REQ-013 b_we  in  1  port B write (1) / read (0).
REQ-014 b_addr  in  19  port B 32-bit word address.
REQ-015 b_be_n  in  4  port B byte enables, active-low.
REQ-016 b_d  in  32  port B write data.
REQ-017 b_q  out  32  port B read data.
REQ-018 b_ack  out  1  port B completion pulse.
REQ-019 ss_a  out  19  SSRAM 32-bit word address.
REQ-020 ss_adsc_n  out  1  SSRAM address strobe (chip enable folded in), active-low.
REQ-021 ss_oe_n  out  1  SSRAM output enable, active-low.
REQ-022 ss_bwe_n  out  1  SSRAM byte-write enable, active-low.
REQ-023 ss_be_n  out  4  SSRAM byte lanes, active-low.
REQ-024 ss_d  out  32  SSRAM write data.
REQ-025 ss_d_oe  out  1  data-bus drive enable for top-level tristate.
REQ-026 ss_q  in  32  SSRAM read data.

Function
REQ-027 States: IDLE, A_RD, A_WR, B_RD, B_WR, DONE; grants are taken only in IDLE.
REQ-028 In IDLE, a_req wins over b_req, except when the starve counter equals STARVE_MAX and b_req is high; then B wins.
REQ-029 A_RD: cycle 0 drives ss_adsc_n=0 with ss_a={a_addr,0}; cycle 1 drives ss_adsc_n=0 with ss_a={a_addr,1}; ss_be_n=0, ss_oe_n=0 from cycle 0 through the last capture.
REQ-030 Each beat's ss_q is captured at the edge RD_LAT cycles after its issue edge; DONE follows the second capture, giving a_rdy high in cycle RD_LAT+2.
REQ-031 A_WR: cycle 0 drives ADSC/BWE low with ss_d=a_d[63:32] and ss_be_n=a_be_n[7:4]; cycle 1 drives ss_d=a_d[31:0] and ss_be_n=a_be_n[3:0]; DONE is in cycle 2.
REQ-032 B_RD/B_WR: single-beat version of the above at ss_a=b_addr; read DONE in cycle RD_LAT+1, write DONE in cycle 1.
REQ-033 DONE lasts one cycle: a_rdy or b_ack equals 1 for exactly that cycle; a_q/b_q are valid in DONE and held until the next read on that port; then IDLE.
REQ-034 Requesters drop req at the edge ending DONE; IDLE never re-grants a completed request.
REQ-035 ss_d_oe is 1 only in write issue cycles; otherwise ss_d=0.
REQ-036 Inactive outputs: ss_adsc_n=1, ss_oe_n=1, ss_bwe_n=1, ss_be_n=4'hF.
REQ-037 The starve counter (8-bit) increments on each A grant while b_req is high, saturates at STARVE_MAX, and clears on a B grant.

Reset
REQ-038 xresetl low forces IDLE, starve counter 0, a_q=0, b_q=0, a_rdy=0, b_ack=0 and all inactive SSRAM levels immediately, even mid-transaction; an aborted transaction produces no rdy/ack.
REQ-039 After reset release, the first IDLE cycle samples requests normally.

Configuration
REQ-040 SSRAM_ARB_STARVE_EN defined: the starve counter and forced B grant per REQ-028/037 are built in.
REQ-041 SSRAM_ARB_STARVE_EN undefined: the counter is absent, A always wins, and STARVE_MAX is ignored.

Verification
REQ-042 RD_LAT=2, A read a_addr=0x00010 -> ss_a 0x00020 then 0x00021 on consecutive ADSC cycles; a_q={M[0x20],M[0x21]}; a_rdy single pulse in cycle 4.
REQ-043 A write a_d=0x1122334455667788, a_be_n=8'h0F -> beat0 ss_d=0x11223344/be_n=0; beat1 ss_d=0x55667788/be_n=F; a_rdy in cycle 2.
REQ-044 B write b_addr=0x7FFFF, b_d=0xDEADBEEF, then B read -> b_q=0xDEADBEEF; b_ack one cycle each.
REQ-045 a_req and b_req held high, STARVE_MAX=8, macro defined -> exactly 8 A grants then 1 B grant, repeating; macro undefined -> no B grant while a_req is high.
REQ-046 xresetl pulsed low in A_RD cycle 1 -> strobes inactive without a clock edge; no a_rdy; the next a_req after release completes normally.

Source files
------------

// File: rtl/ssram_arb.sv
// rtl/ssram_arb.sv - two-port arbiter in front of a 32-bit synchronous-burst SSRAM
//
// Port A (64-bit, Jaguar DRAM side) is split into two 32-bit SSRAM beats,
// even word first. Port B (32-bit, loader/debug) is a single beat. Grants
// are taken only in IDLE; A normally has priority.
//
// Build option: define SSRAM_ARB_STARVE_EN to add the starvation counter that
// forces a B grant after STARVE_MAX consecutive A grants with b_req pending.
// Without it A always wins and STARVE_MAX is only range-checked.
//
// Parameters
//   RD_LAT      SSRAM read latency, ADSC issue edge to capture edge (1..4)
//   STARVE_MAX  A grants tolerated while B waits (1..255)
// Ports
//   sys_clk, xresetl           clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_be_n/a_d   port A request (held until a_rdy)
//   a_q, a_rdy                 port A read data / completion pulse
//   b_req/b_we/b_addr/b_be_n/b_d   port B request (held until b_ack)
//   b_q, b_ack                 port B read data / completion pulse
//   ss_a, ss_adsc_n, ss_oe_n, ss_bwe_n, ss_be_n, ss_d, ss_d_oe, ss_q
//                              SSRAM pins; ss_d_oe drives the top-level tristate

module ssram_arb #(
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic        sys_clk,
    input  logic        xresetl,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [17:0] a_addr,
    input  logic [7:0]  a_be_n,
    input  logic [63:0] a_d,
    output logic [63:0] a_q,
    output logic        a_rdy,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [18:0] b_addr,
    input  logic [3:0]  b_be_n,
    input  logic [31:0] b_d,
    output logic [31:0] b_q,
    output logic        b_ack,
    output logic [18:0] ss_a,
    output logic        ss_adsc_n,
    output logic        ss_oe_n,
    output logic        ss_bwe_n,
    output logic [3:0]  ss_be_n,
    output logic [31:0] ss_d,
    output logic        ss_d_oe,
    input  logic [31:0] ss_q
);

    generate
        if (RD_LAT < 1 || RD_LAT > 4 || STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_param
            $error("ssram_arb: parameter out of legal range");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        A_RD,
        A_WR,
        B_RD,
        B_WR,
        DONE
    } state_t;

    // Cycle index within a transaction state; cycle 0 is the first cycle
    // after the grant edge. RD_LAT+1 <= 5 fits in three bits.
    localparam logic [2:0] LAT  = 3'(RD_LAT);
    localparam logic [2:0] LAT1 = 3'(RD_LAT + 1);

    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] hi_q;       // even-word beat of an A read, held until beat 1 lands
    logic [31:0] a_lo_d;     // odd-word write data, latched at grant
    logic [3:0]  a_lo_be;    // odd-word byte enables, latched at grant

    logic force_b;
    logic grant_a;
    logic grant_b;

`ifdef SSRAM_ARB_STARVE_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    logic [7:0] starve;

    always_comb begin
        force_b = b_req && (starve == STARVE_LIM);
    end
`else
    always_comb begin
        force_b = 1'b0;
    end
`endif

    always_comb begin
        grant_a = a_req && !force_b;
        grant_b = b_req && !grant_a;
    end

`ifdef SSRAM_ARB_STARVE_EN
    // Counts A grants taken while B was waiting; a B grant clears it.
    always_ff @(posedge sys_clk or negedge xresetl) begin
        if (!xresetl) begin
            starve <= 8'd0;
        end else if (state == IDLE) begin
            if (grant_a) begin
                if (b_req && starve != STARVE_LIM) begin
                    starve <= starve + 8'd1;
                end
            end else if (grant_b) begin
                starve <= 8'd0;
            end
        end
    end
`endif

    always_ff @(posedge sys_clk or negedge xresetl) begin
        if (!xresetl) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            hi_q      <= 32'd0;
            a_lo_d    <= 32'd0;
            a_lo_be   <= 4'hF;
            a_q       <= 64'd0;
            a_rdy     <= 1'b0;
            b_q       <= 32'd0;
            b_ack     <= 1'b0;
            ss_a      <= 19'd0;
            ss_adsc_n <= 1'b1;
            ss_oe_n   <= 1'b1;
            ss_bwe_n  <= 1'b1;
            ss_be_n   <= 4'hF;
            ss_d      <= 32'd0;
            ss_d_oe   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 3'd0;
                    if (grant_a) begin
                        // Outputs are registered, so cycle-0 pin levels are set here.
                        ss_a      <= {a_addr, 1'b0};
                        ss_adsc_n <= 1'b0;
                        if (a_we) begin
                            state    <= A_WR;
                            ss_bwe_n <= 1'b0;
                            ss_be_n  <= a_be_n[7:4];
                            ss_d     <= a_d[63:32];
                            ss_d_oe  <= 1'b1;
                            a_lo_d   <= a_d[31:0];
                            a_lo_be  <= a_be_n[3:0];
                        end else begin
                            state   <= A_RD;
                            ss_oe_n <= 1'b0;
                            ss_be_n <= 4'h0;
                        end
                    end else if (grant_b) begin
                        ss_a      <= b_addr;
                        ss_adsc_n <= 1'b0;
                        if (b_we) begin
                            state    <= B_WR;
                            ss_bwe_n <= 1'b0;
                            ss_be_n  <= b_be_n;
                            ss_d     <= b_d;
                            ss_d_oe  <= 1'b1;
                        end else begin
                            state   <= B_RD;
                            ss_oe_n <= 1'b0;
                            ss_be_n <= 4'h0;
                        end
                    end
                end

                A_RD: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd0) begin
                        ss_a <= {ss_a[18:1], 1'b1};
                    end
                    if (cnt == 3'd1) begin
                        ss_adsc_n <= 1'b1;
                    end
                    // Beat 0 was issued at the end of cycle 0, beat 1 one cycle later.
                    if (cnt == LAT) begin
                        hi_q <= ss_q;
                    end
                    if (cnt == LAT1) begin
                        a_q     <= {hi_q, ss_q};
                        a_rdy   <= 1'b1;
                        ss_oe_n <= 1'b1;
                        ss_be_n <= 4'hF;
                        state   <= DONE;
                    end
                end

                A_WR: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd0) begin
                        ss_a    <= {ss_a[18:1], 1'b1};
                        ss_d    <= a_lo_d;
                        ss_be_n <= a_lo_be;
                    end else begin
                        ss_adsc_n <= 1'b1;
                        ss_bwe_n  <= 1'b1;
                        ss_be_n   <= 4'hF;
                        ss_d      <= 32'd0;
                        ss_d_oe   <= 1'b0;
                        a_rdy     <= 1'b1;
                        state     <= DONE;
                    end
                end

                B_RD: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd0) begin
                        ss_adsc_n <= 1'b1;
                    end
                    if (cnt == LAT) begin
                        b_q     <= ss_q;
                        b_ack   <= 1'b1;
                        ss_oe_n <= 1'b1;
                        ss_be_n <= 4'hF;
                        state   <= DONE;
                    end
                end

                B_WR: begin
                    ss_adsc_n <= 1'b1;
                    ss_bwe_n  <= 1'b1;
                    ss_be_n   <= 4'hF;
                    ss_d      <= 32'd0;
                    ss_d_oe   <= 1'b0;
                    b_ack     <= 1'b1;
                    state     <= DONE;
                end

                DONE: begin
                    // Requesters drop req at the edge ending this cycle.
                    a_rdy <= 1'b0;
                    b_ack <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
